// File: rtl/accumulator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accumulator_pkg
//  Description : Shared encodings for the accumulator memory bus: op codes,
//                processor one-hot states and memory-side states.
//  Revision    : 1.0
// ============================================================================
package accumulator_pkg;

    localparam int c_default_width = 32;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_FETCH = 2'b01,
        OP_SEND  = 2'b10
    } op_e;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_FETCH_A = 6'b000010,
        ST_FETCH_B = 6'b000100,
        ST_ADD     = 6'b001000,
        ST_SEND    = 6'b010000,
        ST_HALT    = 6'b100000
    } proc_state_e;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'b00,
        MEM_WAIT = 2'b01,
        MEM_RESP = 2'b10
    } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/accumulator_op_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : accumulator_op_issuer
//  Description : Bus handshake for one op at a time: holds op until signal,
//                enforces the idle gap and gates new issue on stall.
//  Revision    : 1.0
// ============================================================================
module accumulator_op_issuer
    import accumulator_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req,
    input  op_e              i_req_op,
    input  logic             i_stall,
    input  logic             i_signal,
    input  logic [WIDTH-1:0] i_read,
    output op_e              o_op,
    output logic             o_ready,
    output logic             o_done,
    output logic [WIDTH-1:0] o_rdata
);

    typedef enum logic [1:0] {
        ISS_READY  = 2'b00,
        ISS_ACTIVE = 2'b01,
        ISS_GAP    = 2'b10
    } iss_state_e;

    iss_state_e r_state;
    iss_state_e w_next_state;
    op_e        r_op;
    op_e        r_pend_op;
    op_e        w_issue_op;
    logic       r_pending;
    logic       w_issue;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ISS_READY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A request that arrives while the bus is busy or in its gap is parked
    // in r_pending and issued as soon as the bus is free and stall is low.
    always_comb begin
        w_next_state = r_state;
        o_ready      = 1'b0;
        o_done       = 1'b0;
        w_issue      = 1'b0;
        w_issue_op   = i_req ? i_req_op : r_pend_op;
        case (r_state)
            ISS_READY: begin
                o_ready = !i_stall;
                if (!i_stall && (i_req || r_pending)) begin
                    w_issue      = 1'b1;
                    w_next_state = ISS_ACTIVE;
                end
            end
            ISS_ACTIVE: begin
                if (i_signal) begin
                    o_done       = 1'b1;
                    w_next_state = ISS_GAP;
                end
            end
            ISS_GAP:  w_next_state = ISS_READY;
            default:  w_next_state = ISS_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op      <= OP_NOP;
            r_pending <= 1'b0;
            r_pend_op <= OP_NOP;
        end else begin
            if (w_issue) begin
                r_op <= w_issue_op;
            end else if (o_done) begin
                r_op <= OP_NOP;
            end
            if (w_issue) begin
                r_pending <= 1'b0;
            end else if (i_req) begin
                r_pending <= 1'b1;
                r_pend_op <= i_req_op;
            end
        end
    end

    assign o_op    = r_op;
    assign o_rdata = i_read;

endmodule
`default_nettype wire

// File: rtl/accumulator_processor.sv
`default_nettype none
// ============================================================================
//  Module      : accumulator_processor
//  Description : Processor side of the accumulator bus: fetch two operands,
//                add after a compute delay, send the sum, halt on a zero fetch.
//  Revision    : 1.0
// ============================================================================
module accumulator_processor
    import accumulator_pkg::*;
#(
    parameter int WIDTH      = c_default_width,
    parameter int ADD_CYCLES = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 stall,
    input  logic                 signal,
    input  logic [WIDTH-1:0]     read,
    output logic [1:0]           op,
    output logic [WIDTH-1:0]     write,
    output logic                 busy,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] add_count,
    output logic [5:0]           state
);

    localparam int                 c_dly_w    = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;
    localparam logic [c_dly_w-1:0] c_dly_load = c_dly_w'(ADD_CYCLES - 1);

    proc_state_e          r_state;
    proc_state_e          w_next_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_write;
    logic [c_dly_w-1:0]   r_dly;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_req;
    op_e                  w_req_op;
    op_e                  w_op;
    logic                 w_ready;
    logic                 w_done;
    logic [WIDTH-1:0]     w_rdata;

    accumulator_op_issuer #(
        .WIDTH (WIDTH)
    ) u_issuer (
        .clk      (clk),
        .reset    (reset),
        .i_req    (w_req),
        .i_req_op (w_req_op),
        .i_stall  (stall),
        .i_signal (signal),
        .i_read   (read),
        .o_op     (w_op),
        .o_ready  (w_ready),
        .o_done   (w_done),
        .o_rdata  (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_req_op     = OP_NOP;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_ready) begin
                    w_next_state = ST_FETCH_A;
                    w_req        = 1'b1;
                    w_req_op     = OP_FETCH;
                end
            end
            ST_FETCH_A: begin
                if (w_done) begin
                    if (w_rdata == '0) begin
                        w_next_state = ST_HALT;
                    end else begin
                        w_next_state = ST_FETCH_B;
                        w_req        = 1'b1;
                        w_req_op     = OP_FETCH;
                    end
                end
            end
            ST_FETCH_B: begin
                if (w_done) begin
                    // A lone operand goes straight back unchanged.
                    if (w_rdata == '0) begin
                        w_next_state = ST_SEND;
                        w_req        = 1'b1;
                        w_req_op     = OP_SEND;
                    end else begin
                        w_next_state = ST_ADD;
                    end
                end
            end
            ST_ADD: begin
                if (r_dly == '0) begin
                    w_next_state = ST_SEND;
                    w_req        = 1'b1;
                    w_req_op     = OP_SEND;
                end
            end
            ST_SEND: begin
                if (w_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_HALT:  w_next_state = ST_HALT;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_write <= '0;
            r_dly   <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_FETCH_A: begin
                    if (w_done && (w_rdata != '0)) begin
                        r_a <= w_rdata;
                    end
                end
                ST_FETCH_B: begin
                    if (w_done) begin
                        if (w_rdata == '0) begin
                            r_write <= r_a;
                        end else begin
                            r_b   <= w_rdata;
                            r_dly <= c_dly_load;
                        end
                    end
                end
                ST_ADD: begin
                    if (r_dly == '0) begin
                        r_write <= r_a + r_b;
                    end else begin
                        r_dly <= r_dly - c_dly_w'(1);
                    end
                end
                ST_SEND: begin
                    if (w_done) begin
                        r_count <= r_count + CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign op        = w_op;
    assign write     = r_write;
    assign busy      = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign halted    = (r_state == ST_HALT);
    assign add_count = r_count;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_accumulator_processor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accumulator_processor
//  Description : Bench with a reduction-memory model (sums are written back
//                while operands remain) and a bus protocol monitor.
//  Revision    : 1.0
// ============================================================================
module tb_accumulator_processor;

    localparam int WIDTH      = 32;
    localparam int ADD_CYCLES = 4;
    localparam int CNT_WIDTH  = 16;
    localparam int BUDGET     = 3000;

    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] FETCH = 2'b01;
    localparam logic [1:0] SEND  = 2'b10;
    localparam logic [5:0] S_IDLE = 6'b000001;
    localparam logic [5:0] S_HALT = 6'b100000;

    logic                 clk    = 1'b0;
    logic                 reset  = 1'b0;
    logic                 enable = 1'b0;
    logic                 stall  = 1'b0;
    logic                 signal = 1'b0;
    logic [WIDTH-1:0]     read   = '0;
    logic [1:0]           op;
    logic [WIDTH-1:0]     write;
    logic                 busy;
    logic                 halted;
    logic [CNT_WIDTH-1:0] add_count;
    logic [5:0]           state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [WIDTH-1:0] pool[$];
    logic [WIDTH-1:0] sends[$];
    logic [WIDTH-1:0] pair[$];
    int mem_max_lat   = 0;
    bit mem_hold_send = 1'b0;
    int fetch_b_cyc   = 0;
    int send_seen_cyc = 0;

    accumulator_processor #(
        .WIDTH      (WIDTH),
        .ADD_CYCLES (ADD_CYCLES),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .stall     (stall),
        .signal    (signal),
        .read      (read),
        .op        (op),
        .write     (write),
        .busy      (busy),
        .halted    (halted),
        .add_count (add_count),
        .state     (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: FETCH pops the operand pool (0 when empty); a SEND result is
    // pushed back while other operands remain, otherwise it is the final sum.
    initial begin : memory
        bit               in_txn;
        int               lat;
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] exp_w;
        in_txn = 1'b0;
        lat    = 0;
        forever begin
            @(negedge clk);
            #1;
            signal = 1'b0;
            read   = $urandom;
            if (!reset) begin
                in_txn = 1'b0;
                pair.delete();
            end else if (op == NOP) begin
                in_txn = 1'b0;
            end else begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    lat    = (mem_max_lat > 0) ? $urandom_range(mem_max_lat, 0) : 0;
                    if (op == SEND) send_seen_cyc = cyc;
                end
                if (op == SEND && mem_hold_send) begin
                    lat = lat;
                end else if (lat > 0) begin
                    lat--;
                end else begin
                    signal = 1'b1;
                    in_txn = 1'b0;
                    if (op == FETCH) begin
                        v    = (pool.size() > 0) ? pool.pop_front() : '0;
                        read = v;
                        pair.push_back(v);
                        if (pair.size() == 2) fetch_b_cyc = cyc;
                    end else begin
                        if (pair.size() == 0)
                            exp_w = '0;
                        else if (pair.size() >= 2 && pair[1] != '0)
                            exp_w = pair[0] + pair[1];
                        else
                            exp_w = pair[0];
                        n_checks++;
                        if (write !== exp_w) begin
                            n_fail++;
                            $display("FAIL send_value: got %h expected %h", write, exp_w);
                        end
                        sends.push_back(write);
                        if (pool.size() > 0) pool.push_back(write);
                        pair.delete();
                    end
                end
            end
        end
    end

    // Bus protocol: op held until signal, then two NOP cycles, write stable
    // during SEND, and no new op issued on an edge where stall was high.
    initial begin : protocol_monitor
        logic [1:0]       p_op;
        logic [WIDTH-1:0] p_w;
        bit               gap;
        p_op = NOP;
        p_w  = '0;
        gap  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                p_op = op;
                gap  = 1'b0;
            end else begin
                if (gap) begin
                    gap = 1'b0;
                    n_checks++;
                    if (op !== NOP) begin
                        n_fail++;
                        $display("FAIL nop_gap: op %b expected %b", op, NOP);
                    end
                end
                if (p_op != NOP) begin
                    if (signal) begin
                        gap = 1'b1;
                        n_checks++;
                        if (op !== NOP) begin
                            n_fail++;
                            $display("FAIL op_release: op %b expected %b", op, NOP);
                        end
                    end else begin
                        n_checks++;
                        if (op !== p_op) begin
                            n_fail++;
                            $display("FAIL op_hold: op %b expected %b", op, p_op);
                        end
                        if (p_op == SEND) begin
                            n_checks++;
                            if (write !== p_w) begin
                                n_fail++;
                                $display("FAIL write_stable: write %h expected %h", write, p_w);
                            end
                        end
                    end
                end else if (op != NOP) begin
                    n_checks++;
                    if (stall !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall_issue: op %b issued with stall %b", op, stall);
                    end
                end
                p_op = op;
                p_w  = write;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0; enable = 1'b0; stall = 1'b0; mem_hold_send = 1'b0;
        pool.delete();
        sends.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_halted(input int stall_pct, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (halted === 1'b1) begin
                ok = 1'b1;
                break;
            end
            stall = ($urandom_range(99, 0) < stall_pct);
        end
        stall = 1'b0;
    endtask

    task automatic wait_op(input logic [1:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (op === target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %b expected %b", state, S_IDLE); end
        n_checks++; if (op !== NOP) begin n_fail++; $display("FAIL reset_op: got %b expected %b", op, NOP); end
        n_checks++; if (write !== '0) begin n_fail++; $display("FAIL reset_write: got %h expected 0", write); end
        n_checks++; if (add_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", add_count); end
        n_checks++; if (busy !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL reset_flags: busy %b halted %b expected 0 0", busy, halted); end
    endtask

    task automatic test_basic_add();
        bit ok;
        apply_reset();
        pool = '{32'd5, 32'd7};
        mem_max_lat = 0;
        enable = 1'b1;
        wait_op(SEND, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_send_timeout: no SEND seen, expected one"); end
        n_checks++; if (write !== 32'd12) begin n_fail++; $display("FAIL basic_sum: got %0d expected 12", write); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
        wait_halted(0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_halt_timeout: halted %b expected 1", halted); end
        n_checks++; if (add_count !== 16'd1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", add_count); end
        n_checks++; if (op !== NOP || busy !== 1'b0) begin n_fail++; $display("FAIL basic_halt_bus: op %b busy %b expected 00 0", op, busy); end
        n_checks++;
        if (send_seen_cyc - fetch_b_cyc < ADD_CYCLES + 1) begin
            n_fail++;
            $display("FAIL add_delay: %0d cycles expected at least %0d", send_seen_cyc - fetch_b_cyc, ADD_CYCLES + 1);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        apply_reset();
        pool = '{32'hFFFF_FFFF, 32'd2};
        enable = 1'b1;
        wait_halted(0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout: halted %b expected 1", halted); end
        n_checks++;
        if (sends.size() != 1 || sends[0] !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL wrap_sum: got %0d sends first %h expected 1 send of 00000001", sends.size(), (sends.size() > 0) ? sends[0] : '0);
        end
    endtask

    task automatic test_lone();
        bit ok;
        apply_reset();
        pool = '{32'd9};
        enable = 1'b1;
        wait_halted(0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL lone_timeout: halted %b expected 1", halted); end
        n_checks++;
        if (sends.size() != 1 || sends[0] !== 32'd9) begin
            n_fail++;
            $display("FAIL lone_value: got %0d sends expected 1 send of 9", sends.size());
        end
        n_checks++; if (add_count !== 16'd1) begin n_fail++; $display("FAIL lone_count: got %0d expected 1", add_count); end
        n_checks++;
        if (send_seen_cyc - fetch_b_cyc >= ADD_CYCLES + 1) begin
            n_fail++;
            $display("FAIL lone_no_add: %0d cycles expected fewer than %0d", send_seen_cyc - fetch_b_cyc, ADD_CYCLES + 1);
        end
    endtask

    task automatic test_stall_idle();
        bit ok;
        int bad;
        apply_reset();
        pool = '{32'd5, 32'd7};
        @(negedge clk);
        stall = 1'b1;
        enable = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (op !== NOP) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d op %b expected %b", i, op, NOP);
            end
        end
        stall = 1'b0;
        @(negedge clk);
        n_checks++; if (op !== FETCH) begin n_fail++; $display("FAIL stall_release: op %b expected %b", op, FETCH); end
        wait_halted(0, ok);
        n_checks++; if (!ok || add_count !== 16'd1) begin n_fail++; $display("FAIL stall_finish: halted %b count %0d expected 1 1", halted, add_count); end
    endtask

    task automatic test_halt_sticky();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            enable = $urandom_range(1, 0);
            n_checks++;
            if (state !== S_HALT || op !== NOP || halted !== 1'b1) begin
                n_fail++;
                $display("FAIL halt_sticky: state %b op %b expected %b %b", state, op, S_HALT, NOP);
            end
        end
    endtask

    task automatic test_random_1234();
        bit ok;
        for (int run = 0; run < 40; run++) begin
            apply_reset();
            pool = '{32'd1, 32'd2, 32'd3, 32'd4};
            mem_max_lat = $urandom_range(3, 0);
            enable = 1'b1;
            wait_halted($urandom_range(80, 0), ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL r1234_timeout: run %0d halted %b expected 1", run, halted); end
            n_checks++;
            if (sends.size() == 0 || sends[sends.size()-1] !== 32'd10) begin
                n_fail++;
                $display("FAIL r1234_final: run %0d sends %0d expected final 10", run, sends.size());
            end
            n_checks++; if (add_count !== 16'd3) begin n_fail++; $display("FAIL r1234_count: run %0d got %0d expected 3", run, add_count); end
        end
    endtask

    task automatic test_random_operands();
        bit ok;
        int n;
        int exp_cnt;
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] total;
        for (int run = 0; run < 30; run++) begin
            apply_reset();
            n = $urandom_range(6, 0);
            total = '0;
            for (int k = 0; k < n; k++) begin
                v = ($urandom_range(1, 0) == 1) ? $urandom : $urandom_range(100, 1);
                if (v == '0) v = 32'd1;
                pool.push_back(v);
                total = total + v;
            end
            exp_cnt = (n == 0) ? 0 : ((n == 1) ? 1 : n - 1);
            mem_max_lat = $urandom_range(2, 0);
            enable = 1'b1;
            wait_halted($urandom_range(60, 0), ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_timeout: run %0d halted %b expected 1", run, halted); end
            n_checks++; if (add_count !== CNT_WIDTH'(exp_cnt)) begin n_fail++; $display("FAIL rand_count: run %0d got %0d expected %0d", run, add_count, exp_cnt); end
            if (n > 0) begin
                n_checks++;
                if (sends.size() == 0 || sends[sends.size()-1] !== total) begin
                    n_fail++;
                    $display("FAIL rand_total: run %0d sends %0d expected final %h", run, sends.size(), total);
                end
            end
        end
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        apply_reset();
        pool = '{32'd1, 32'd2, 32'd3, 32'd4};
        mem_max_lat = 0;
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (add_count === 16'd1) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midsend_first: count %0d expected 1", add_count); end
        mem_hold_send = 1'b1;
        wait_op(SEND, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midsend_timeout: op %b expected %b", op, SEND); end
        reset = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mem_hold_send = 1'b0;
        n_checks++; if (op !== NOP) begin n_fail++; $display("FAIL midsend_op: got %b expected %b", op, NOP); end
        n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL midsend_state: got %b expected %b", state, S_IDLE); end
        n_checks++; if (add_count !== '0) begin n_fail++; $display("FAIL midsend_count: got %0d expected 0", add_count); end
        n_checks++; if (write !== '0) begin n_fail++; $display("FAIL midsend_write: got %h expected 0", write); end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_wrap();
        test_lone();
        test_stall_idle();
        test_halt_sticky();
        test_reset_mid_send();
        test_random_1234();
        test_random_operands();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
